move_entry_debouncer: RTL and testbench
=======================================

// Module: move_entry_debouncer
// PURPOSE
//   Front end for the human player's move. Synchronises the raw move switches and the raw
//   active-low "enter" key, then debounces the key. Each clean press produces exactly one
//   validated 4-bit move, offered to the game FSM downstream on a valid/ready handshake.
//   Out-of-range moves are rejected with a one-cycle error pulse and are never offered.
// PARAMETERS
//   DEBOUNCE_CYCLES  250000  clocks the key must stay stable to count as a press or a release (>=2)
//   MAX_MOVE         8       largest legal move value; captured values above it are illegal
// PORTS
//   clock       in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-high reset
//   key_n       in   1  raw enter key, active-low, asynchronous and bouncy
//   sw_move     in   4  raw move switches, asynchronous
//   move_ready  in   1  downstream FSM accepts the move this cycle
//   move_valid  out  1  move holds a legal, captured move
//   move        out  4  captured move value, stable while move_valid=1
//   move_err    out  1  one-cycle pulse: captured move > MAX_MOVE
//   busy        out  1  block is not in IDLE
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-high.
//   - Reset values: move_valid=0, move=0, move_err=0, busy=0, state=IDLE, counter=0.
//     key synchroniser flops reset to 1 (key released); switch synchroniser flops reset to 0.
//   - Synchronisers: 2-flop chains on key_n and on each sw_move bit.
//     pressed = ~key_n_sync. All decisions use the synchronised signals only.
//   - Debounce counter: width $clog2(DEBOUNCE_CYCLES). Cleared on every state entry.
//   - FSM states and transitions (all outputs are registered):
//     IDLE      : pressed -> PRESS_DB.
//     PRESS_DB  : !pressed -> IDLE (bounce rejected). Otherwise cnt++.
//                 At cnt==DEBOUNCE_CYCLES-1, capture sw_move_sync into move.
//                 If the captured value <= MAX_MOVE -> OFFER.
//                 Else -> WAIT_REL, with move_err=1 for exactly the next cycle.
//     OFFER     : move_valid=1, move frozen; switch changes are ignored.
//                 move_valid & move_ready -> WAIT_REL, and move_valid falls the next cycle.
//                 Key release during OFFER is ignored; the offer persists until accepted.
//     WAIT_REL  : !pressed -> REL_DB.
//     REL_DB    : pressed -> WAIT_REL (bounce). Otherwise cnt++.
//                 At cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//   - Latency: count the first rising edge that samples key_n=0 as edge 1, with key_n held low.
//     move_valid (or move_err) rises after edge DEBOUNCE_CYCLES+3.
//     Ready may already be high at that point: a transfer costs 1 cycle of move_valid.
//   - One move per press: holding the key indefinitely never re-offers a move.
//     A new move requires a debounced release followed by a debounced press.
//   - move keeps its last captured value after the transfer, until the next capture.
//   - busy = (state != IDLE).
//   - Reset asserted mid-operation (including OFFER): all outputs go to their reset values
//     immediately and asynchronously. The pending move is dropped, not replayed.
//   - move_valid and move_err are never both 1.
// TESTING (DEBOUNCE_CYCLES=4, MAX_MOVE=8)
//   1. sw_move=5, key_n low 20 cycles, move_ready=1 -> move_valid=1 for exactly 1 cycle
//      after edge 7, move=5. After key_n high 8 cycles -> busy=0.
//   2. key_n low 3 cycles, then high -> no move_valid, no move_err; busy returns to 0.
//   3. sw_move=12, clean press -> move_err pulses 1 cycle, move_valid stays 0.
//      busy stays 1 until a debounced release.
//   4. sw_move=5, press, move_ready=0 for 10 cycles, sw_move changed to 2 mid-offer
//      -> move_valid held, move=5 throughout. Raise move_ready -> single transfer of 5.
//   5. After a transfer, key held 50 cycles -> no second move_valid. Release bounces
//      (high 2, low 1, high 10) -> REL_DB restarts; IDLE is reached 4 stable cycles after the last bounce.
//   6. reset pulsed during OFFER -> move_valid=0, busy=0, move=0 immediately.
//      Next clean press with sw_move=3 -> move=3 offered.

Source files
------------

// File: rtl/move_entry_debouncer.sv
// Move entry front end: synchronises the move switches and the active-low enter key,
// debounces the key and offers exactly one validated move per clean press.
module move_entry_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_MOVE        = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_n,
    input  logic [3:0] sw_move,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [3:0] move,
    output logic       move_err,
    output logic       busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] MAX_MOVE_L = 5'(MAX_MOVE);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        OFFER    = 3'd2,
        WAIT_REL = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [3:0]      move_reg, move_next;
    logic            move_valid_reg, move_valid_next;
    logic            move_err_reg, move_err_next;
    logic            busy_reg, busy_next;

    logic [1:0]      key_sync_reg;
    logic [3:0]      sw_move_sync;
    logic            pressed;

    // Key synchroniser resets to "released" so reset never looks like a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_sync_reg <= 2'b11;
        end else begin
            key_sync_reg <= {key_sync_reg[0], key_n};
        end
    end

    assign pressed = ~key_sync_reg[1];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sw_sync
            logic [1:0] sw_sync_reg;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sw_sync_reg <= 2'b00;
                end else begin
                    sw_sync_reg <= {sw_sync_reg[0], sw_move[gi]};
                end
            end
            assign sw_move_sync[gi] = sw_sync_reg[1];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            move_reg       <= 4'd0;
            move_valid_reg <= 1'b0;
            move_err_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            move_reg       <= move_next;
            move_valid_reg <= move_valid_next;
            move_err_reg   <= move_err_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        move_next       = move_reg;
        move_valid_next = move_valid_reg;
        move_err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pressed) begin
                    state_next = PRESS_DB;
                    cnt_next   = '0;
                end
            end
            PRESS_DB: begin
                if (!pressed) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    move_next = sw_move_sync;
                    cnt_next  = '0;
                    if ({1'b0, sw_move_sync} <= MAX_MOVE_L) begin
                        state_next      = OFFER;
                        move_valid_next = 1'b1;
                    end else begin
                        state_next    = WAIT_REL;
                        move_err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            OFFER: begin
                // Key state is deliberately ignored here: the offer stands until taken.
                if (move_valid_reg && move_ready) begin
                    state_next      = WAIT_REL;
                    move_valid_next = 1'b0;
                    cnt_next        = '0;
                end
            end
            WAIT_REL: begin
                if (!pressed) begin
                    state_next = REL_DB;
                    cnt_next   = '0;
                end
            end
            REL_DB: begin
                if (pressed) begin
                    state_next = WAIT_REL;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next      = IDLE;
                cnt_next        = '0;
                move_valid_next = 1'b0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign move_valid = move_valid_reg;
    assign move       = move_reg;
    assign move_err   = move_err_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_move_entry_debouncer.sv
// Bench for move_entry_debouncer: directed scenarios plus randomized bouncy key
// traffic checked cycle by cycle against a run-length reference model.
module tb_move_entry_debouncer;

    localparam int D       = 4;
    localparam int MAXM    = 8;
    localparam int PH_ARMED = 0;
    localparam int PH_OFFER = 1;
    localparam int PH_HELD  = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_n = 1'b1;
    logic [3:0] sw_move = 4'd0;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [3:0] move;
    logic       move_err;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;
    int n_errp   = 0;
    logic [3:0] last_xfer_move = 4'd0;

    // Reference model state: phase plus run lengths of the synchronised key level.
    logic       mq_key[$];
    logic [3:0] mq_sw[$];
    int         m_phase;
    int         m_run_p;
    int         m_run_r;
    logic [3:0] m_move;
    logic       m_err;

    move_entry_debouncer #(.DEBOUNCE_CYCLES(D), .MAX_MOVE(MAXM)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .sw_move    (sw_move),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move       (move),
        .move_err   (move_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        mq_key.delete();
        mq_sw.delete();
        mq_key.push_back(1'b1);
        mq_key.push_back(1'b1);
        mq_sw.push_back(4'd0);
        mq_sw.push_back(4'd0);
        m_phase = PH_ARMED;
        m_run_p = 0;
        m_run_r = 0;
        m_move  = 4'd0;
        m_err   = 1'b0;
    endfunction

    // A key level is visible to the decision logic two edges after it is sampled.
    // A press is accepted once D+1 consecutive edges see it; same for a release.
    function automatic void model_edge(input logic k, input logic [3:0] sw, input logic rdy);
        logic       seen_k;
        logic [3:0] seen_sw;
        seen_k  = mq_key.pop_front();
        seen_sw = mq_sw.pop_front();
        mq_key.push_back(k);
        mq_sw.push_back(sw);
        m_err = 1'b0;
        if (m_phase == PH_ARMED) begin
            if (!seen_k) begin
                m_run_p = m_run_p + 1;
                if (m_run_p == D + 1) begin
                    m_move  = seen_sw;
                    m_run_r = 0;
                    if (int'(seen_sw) <= MAXM) begin
                        m_phase = PH_OFFER;
                    end else begin
                        m_phase = PH_HELD;
                        m_err   = 1'b1;
                    end
                end
            end else begin
                m_run_p = 0;
            end
        end else if (m_phase == PH_OFFER) begin
            if (rdy) begin
                m_phase = PH_HELD;
                m_run_r = 0;
            end
        end else begin
            if (seen_k) begin
                m_run_r = m_run_r + 1;
                if (m_run_r == D + 1) begin
                    m_phase = PH_ARMED;
                    m_run_p = 0;
                end
            end else begin
                m_run_r = 0;
            end
        end
    endfunction

    // Drives one cycle from a falling edge to the next falling edge.
    task automatic drive(input logic k, input logic [3:0] sw, input logic rdy);
        key_n      = k;
        sw_move    = sw;
        move_ready = rdy;
        if (move_valid === 1'b1 && rdy) begin
            n_xfer++;
            last_xfer_move = move;
            $display("t=%0t transfer move=%0d", $time, move);
        end
        @(posedge clock);
        model_edge(k, sw, rdy);
        @(negedge clock);
        if (move_err === 1'b1) begin
            n_errp++;
            $display("t=%0t reject move=%0d", $time, move);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (move_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", move_valid); else n_pass++;
        n_checks++; if (move !== 4'd0) $display("FAIL reset_move got=%0d exp=0", move); else n_pass++;
        n_checks++; if (move_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", move_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_press();
        int first_valid = -1;
        int valid_cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 4'd5, 1'b1);
            if (move_valid === 1'b1) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = i;
            end
        end
        n_checks++; if (first_valid != D + 3) $display("FAIL basic_latency got=%0d exp=%0d", first_valid, D + 3); else n_pass++;
        n_checks++; if (valid_cycles != 1) $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cycles); else n_pass++;
        n_checks++; if (move !== 4'd5) $display("FAIL basic_move got=%0d exp=5", move); else n_pass++;
        for (int i = 0; i < 8; i++) drive(1'b1, 4'd5, 1'b1);
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after_release got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_short_bounce();
        int valid_cycles = 0;
        int err0 = n_errp;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd6, 1'b1);
            if (move_valid === 1'b1) valid_cycles++;
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'd6, 1'b1);
            if (move_valid === 1'b1) valid_cycles++;
        end
        n_checks++; if (valid_cycles != 0) $display("FAIL bounce_valid got=%0d exp=0", valid_cycles); else n_pass++;
        n_checks++; if (n_errp != err0) $display("FAIL bounce_err got=%0d exp=0", n_errp - err0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL bounce_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_illegal();
        int valid_cycles = 0;
        int err0 = n_errp;
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 4'd12, 1'b1);
            if (move_valid === 1'b1) valid_cycles++;
        end
        n_checks++; if (n_errp - err0 != 1) $display("FAIL illegal_err_cycles got=%0d exp=1", n_errp - err0); else n_pass++;
        n_checks++; if (valid_cycles != 0) $display("FAIL illegal_valid got=%0d exp=0", valid_cycles); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL illegal_busy_held got=%b exp=1", busy); else n_pass++;
        for (int i = 0; i < 10; i++) drive(1'b1, 4'd12, 1'b1);
        n_checks++; if (busy !== 1'b0) $display("FAIL illegal_busy_release got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_hold_offer();
        int bad = 0;
        int x0;
        for (int i = 1; i <= 25; i++) begin
            drive(1'b0, (i >= 10) ? 4'd2 : 4'd5, 1'b0);
            if (i >= D + 3 && (move_valid !== 1'b1 || move !== 4'd5)) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL offer_hold bad_cycles=%0d exp=0", bad); else n_pass++;
        x0 = n_xfer;
        for (int i = 0; i < 3; i++) drive(1'b0, 4'd2, 1'b1);
        n_checks++; if (n_xfer - x0 != 1) $display("FAIL offer_transfers got=%0d exp=1", n_xfer - x0); else n_pass++;
        n_checks++; if (last_xfer_move !== 4'd5) $display("FAIL offer_move got=%0d exp=5", last_xfer_move); else n_pass++;
        n_checks++; if (move_valid !== 1'b0) $display("FAIL offer_valid_after got=%b exp=0", move_valid); else n_pass++;
        for (int i = 0; i < 10; i++) drive(1'b1, 4'd2, 1'b1);
    endtask

    task automatic test_back_to_back();
        int valid_cycles = 0;
        int fall = -1;
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 4'd7, 1'b1);
            if (move_valid === 1'b1) valid_cycles++;
        end
        n_checks++; if (valid_cycles != 1) $display("FAIL hold_single_move got=%0d exp=1", valid_cycles); else n_pass++;
        drive(1'b1, 4'd7, 1'b1);
        drive(1'b1, 4'd7, 1'b1);
        drive(1'b0, 4'd7, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 4'd7, 1'b1);
            if (fall < 0 && busy === 1'b0) fall = i;
        end
        n_checks++; if (fall != D + 3) $display("FAIL release_bounce_idle got=%0d exp=%0d", fall, D + 3); else n_pass++;
    endtask

    task automatic test_reset_offer();
        for (int i = 0; i < 10; i++) drive(1'b0, 4'd5, 1'b0);
        n_checks++; if (move_valid !== 1'b1) $display("FAIL rst_pre_offer got=%b exp=1", move_valid); else n_pass++;
        key_n = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++; if (move_valid !== 1'b0) $display("FAIL rst_async_valid got=%b exp=0", move_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (move !== 4'd0) $display("FAIL rst_async_move got=%0d exp=0", move); else n_pass++;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        begin
            int x0 = n_xfer;
            for (int i = 0; i < 12; i++) drive(1'b0, 4'd3, 1'b1);
            n_checks++; if (n_xfer - x0 != 1) $display("FAIL rst_next_transfers got=%0d exp=1", n_xfer - x0); else n_pass++;
            n_checks++; if (last_xfer_move !== 4'd3) $display("FAIL rst_next_move got=%0d exp=3", last_xfer_move); else n_pass++;
        end
        for (int i = 0; i < 10; i++) drive(1'b1, 4'd3, 1'b1);
    endtask

    task automatic test_random();
        logic       k = 1'b1;
        logic [3:0] sw = 4'd0;
        logic       rdy;
        int         len;
        for (int r = 0; r < 160; r++) begin
            k   = ~k;
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 2) == 0) sw = 4'($urandom_range(0, 15));
            for (int c = 0; c < len; c++) begin
                rdy = ($urandom_range(0, 2) != 0);
                drive(k, sw, rdy);
                n_checks++; if (move_valid !== (m_phase == PH_OFFER)) $display("FAIL rand_valid t=%0t got=%b exp=%b", $time, move_valid, (m_phase == PH_OFFER)); else n_pass++;
                n_checks++; if (move_err !== m_err) $display("FAIL rand_err t=%0t got=%b exp=%b", $time, move_err, m_err); else n_pass++;
                n_checks++; if (move !== m_move) $display("FAIL rand_move t=%0t got=%0d exp=%0d", $time, move, m_move); else n_pass++;
                n_checks++; if (busy !== !(m_phase == PH_ARMED && m_run_p == 0)) $display("FAIL rand_busy t=%0t got=%b exp=%b", $time, busy, !(m_phase == PH_ARMED && m_run_p == 0)); else n_pass++;
            end
        end
        for (int i = 0; i < 12; i++) drive(1'b1, sw, 1'b1);
        n_checks++; if (busy !== 1'b0) $display("FAIL rand_final_busy got=%b exp=0", busy); else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_press();
        test_short_bounce();
        test_illegal();
        test_hold_offer();
        test_back_to_back();
        test_reset_offer();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
